// File: rtl/cohort_dbg_pkg.sv
// Shared constants and types for the cohort debug-register snapshot path.
package cohort_dbg_pkg;

    localparam int unsigned DbgWordW = 32;
    localparam int unsigned SnapCntW = 16;

    typedef enum logic {
        DBG_SNAP_IDLE,
        DBG_SNAP_STREAM
    } dbg_snap_state_e;

endpackage

// File: rtl/cohort_dbg_if.sv
// Debug-word bundle published by a producer and sampled by debug consumers.
interface cohort_dbg_if #(
    parameter int unsigned RegNum = 1
);

    logic [RegNum-1:0][cohort_dbg_pkg::DbgWordW-1:0] dbg_data;

    modport master (output dbg_data);
    modport slave  (input  dbg_data);

endinterface

// File: rtl/cohort_dbg_snapshot.sv
// Captures all debug words atomically on request, then streams them out one
// word per valid/ready beat so a readout stays coherent while the producer runs.
module cohort_dbg_snapshot
    import cohort_dbg_pkg::*;
#(
    parameter int unsigned RegNum = 1,
    parameter int unsigned IdxW   = (RegNum > 1) ? $clog2(RegNum) : 1
) (
    input  logic                clk,
    input  logic                rst,
    cohort_dbg_if.slave         dbg,
    input  logic                snap_req_valid,
    output logic                snap_req_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DbgWordW-1:0] out_data,
    output logic [IdxW-1:0]     out_idx,
    output logic                out_last,
    output logic                busy,
    output logic [SnapCntW-1:0] snap_count
);

    localparam logic [IdxW-1:0] LastIdx = IdxW'(RegNum - 1);

    dbg_snap_state_e                   state;
    logic [IdxW-1:0]                   idx;
    logic [RegNum-1:0][DbgWordW-1:0]   snap;
    logic [SnapCntW-1:0]               snap_cnt_q;
    logic                              at_last;

    assign snap_count = snap_cnt_q;

    // Handshake flags and read mux; data/idx/last are forced to zero when idle.
    always_comb begin
        at_last        = (idx == LastIdx);
        snap_req_ready = (state == DBG_SNAP_IDLE);
        busy           = (state == DBG_SNAP_STREAM);
        out_valid      = (state == DBG_SNAP_STREAM);
        out_data       = '0;
        out_idx        = '0;
        out_last       = 1'b0;
        if (state == DBG_SNAP_STREAM) begin
            out_idx  = idx;
            out_last = at_last;
            for (int unsigned i = 0; i < RegNum; i++) begin
                if (idx == IdxW'(i)) begin
                    out_data = snap[i];
                end
            end
        end
    end

    // Snapshot bank is only written on request acceptance, never while streaming.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= DBG_SNAP_IDLE;
            idx        <= '0;
            snap       <= '0;
            snap_cnt_q <= '0;
        end else begin
            case (state)
                DBG_SNAP_IDLE: begin
                    if (snap_req_valid) begin
                        snap  <= dbg.dbg_data;
                        idx   <= '0;
                        state <= DBG_SNAP_STREAM;
                    end
                end
                DBG_SNAP_STREAM: begin
                    if (out_ready) begin
                        if (at_last) begin
                            idx        <= '0;
                            state      <= DBG_SNAP_IDLE;
                            snap_cnt_q <= snap_cnt_q + SnapCntW'(1);
                        end else begin
                            idx <= idx + IdxW'(1);
                        end
                    end
                end
                default: state <= DBG_SNAP_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cohort_dbg_snapshot.sv
// Randomized and directed bench for cohort_dbg_snapshot (RegNum=4 and RegNum=1)
// against a queue-based model of captured-but-unstreamed words.
module tb_cohort_dbg_snapshot;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst4, rst1;
    logic        req4, req1, rdy4, rdy1;
    logic        sreq_rdy4, sreq_rdy1, ov4, ov1, ol4, ol1, busy4, busy1;
    logic [31:0] od4, od1;
    logic [1:0]  oi4;
    logic [0:0]  oi1;
    logic [15:0] cnt4o, cnt1o;

    cohort_dbg_if #(.RegNum(4)) dbg4 ();
    cohort_dbg_if #(.RegNum(1)) dbg1 ();

    cohort_dbg_snapshot #(.RegNum(4)) u_dut4 (
        .clk(clk), .rst(rst4), .dbg(dbg4.slave),
        .snap_req_valid(req4), .snap_req_ready(sreq_rdy4),
        .out_valid(ov4), .out_ready(rdy4), .out_data(od4), .out_idx(oi4),
        .out_last(ol4), .busy(busy4), .snap_count(cnt4o)
    );

    cohort_dbg_snapshot #(.RegNum(1)) u_dut1 (
        .clk(clk), .rst(rst1), .dbg(dbg1.slave),
        .snap_req_valid(req1), .snap_req_ready(sreq_rdy1),
        .out_valid(ov1), .out_ready(rdy1), .out_data(od1), .out_idx(oi1),
        .out_last(ol1), .busy(busy1), .snap_count(cnt1o)
    );

    // Model: words captured but not yet streamed, position in snapshot, counters.
    logic [31:0] q4[$], q1[$], seen4[$];
    int pos4 = 0, cnt4 = 0, cnt1 = 0, acc4 = 0, acc1 = 0, done1 = 0;
    int n_assert = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check4();
        bit e;
        e = (q4.size() == 0);
        chk("ready4", 32'(sreq_rdy4), 32'(e));
        chk("busy4",  32'(busy4), 32'(!e));
        chk("valid4", 32'(ov4), 32'(!e));
        chk("data4",  od4, e ? 32'h0 : q4[0]);
        chk("idx4",   32'(oi4), e ? 32'h0 : 32'(pos4));
        chk("last4",  32'(ol4), 32'(!e && pos4 == 3));
        chk("count4", 32'(cnt4o), 32'(cnt4));
    endtask

    task automatic check1();
        bit e;
        e = (q1.size() == 0);
        chk("ready1", 32'(sreq_rdy1), 32'(e));
        chk("busy1",  32'(busy1), 32'(!e));
        chk("valid1", 32'(ov1), 32'(!e));
        chk("data1",  od1, e ? 32'h0 : q1[0]);
        chk("idx1",   32'(oi1), 32'h0);
        chk("last1",  32'(ol1), 32'(!e));
        chk("count1", 32'(cnt1o), 32'(cnt1));
    endtask

    // Called at a negedge with inputs set: check, clock once, update model.
    task automatic tick();
        logic        a4, b4, a1, b1;
        logic [31:0] cap4 [4];
        logic [31:0] cap1;
        check4();
        check1();
        a4 = req4 && (q4.size() == 0);
        b4 = rdy4 && (q4.size() != 0);
        a1 = req1 && (q1.size() == 0);
        b1 = rdy1 && (q1.size() != 0);
        for (int i = 0; i < 4; i++) cap4[i] = dbg4.dbg_data[i];
        cap1 = dbg1.dbg_data[0];
        @(posedge clk);
        if (b4) begin
            seen4.push_back(q4.pop_front());
            if (pos4 == 3) begin
                pos4 = 0;
                cnt4 = (cnt4 + 1) % 65536;
            end else begin
                pos4++;
            end
        end
        if (a4) begin
            for (int i = 0; i < 4; i++) q4.push_back(cap4[i]);
            acc4++;
        end
        if (b1) begin
            void'(q1.pop_front());
            cnt1 = (cnt1 + 1) % 65536;
            done1++;
        end
        if (a1) begin
            q1.push_back(cap1);
            acc1++;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] exp_t1 [4];
        int a0;
        exp_t1[0] = 32'h1; exp_t1[1] = 32'h2; exp_t1[2] = 32'h3; exp_t1[3] = 32'h4;

        // Reset both instances; outputs checked while reset is held.
        rst4 = 1'b1; rst1 = 1'b1;
        req4 = 1'b0; req1 = 1'b0; rdy4 = 1'b0; rdy1 = 1'b0;
        dbg4.dbg_data = '0; dbg1.dbg_data = '0;
        @(negedge clk);
        @(negedge clk);
        check4();
        check1();
        rst4 = 1'b0; rst1 = 1'b0;
        tick();

        // Test 1: basic 4-word snapshot with out_ready high.
        dbg4.dbg_data = {32'h4, 32'h3, 32'h2, 32'h1};
        req4 = 1'b1; rdy4 = 1'b1;
        tick();
        req4 = 1'b0;
        repeat (5) tick();
        chk("t1_beats", 32'(seen4.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("t1_word", seen4[i], exp_t1[i]);
        chk("t1_count", 32'(cnt4o), 32'd1);

        // Test 2: producer overwrites after acceptance; stream must keep captured words.
        for (int i = 0; i < 4; i++) dbg4.dbg_data[i] = $urandom;
        req4 = 1'b1;
        tick();
        req4 = 1'b0;
        dbg4.dbg_data = {4{32'hDEAD_BEEF}};
        repeat (5) tick();

        // Test 3: backpressure 1,0,0,1 with the request held across streams.
        a0 = acc4;
        req4 = 1'b1;
        for (int c = 0; c < 32; c++) begin
            rdy4 = (c % 4 == 0) || (c % 4 == 3);
            for (int i = 0; i < 4; i++) dbg4.dbg_data[i] = $urandom;
            tick();
        end
        chk("t3_accepts", 32'(acc4 - a0 >= 3), 32'd1);

        // Randomized traffic on both instances.
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < 4; i++) dbg4.dbg_data[i] = $urandom;
            dbg1.dbg_data[0] = $urandom;
            req4 = 1'($urandom_range(0, 1));
            rdy4 = 1'($urandom_range(0, 1));
            req1 = 1'($urandom_range(0, 1));
            rdy1 = 1'($urandom_range(0, 1));
            tick();
        end
        req4 = 1'b0; req1 = 1'b0; rdy4 = 1'b1; rdy1 = 1'b1;
        repeat (6) tick();
        chk("drain4", 32'(q4.size()), 32'd0);
        chk("drain1", 32'(q1.size()), 32'd0);

        // Test 4: RegNum=1, three held back-to-back requests after a fresh reset.
        rst1 = 1'b1;
        q1.delete(); cnt1 = 0; done1 = 0; acc1 = 0;
        @(posedge clk);
        @(negedge clk);
        rst1 = 1'b0;
        dbg1.dbg_data[0] = 32'hA5A5_0001;
        req1 = 1'b1; rdy1 = 1'b1;
        repeat (6) tick();
        req1 = 1'b0;
        tick();
        chk("t4_done", 32'(done1), 32'd3);
        chk("t4_count", 32'(cnt1o), 32'd3);

        // Test 6: count preloaded to 0xFFFF wraps to 0 on the next snapshot.
        force u_dut1.snap_cnt_q = 16'hFFFF;
        #1;
        release u_dut1.snap_cnt_q;
        cnt1 = 65535;
        tick();
        req1 = 1'b1;
        tick();
        req1 = 1'b0;
        tick();
        tick();
        chk("t6_wrap", 32'(cnt1o), 32'd0);

        // Test 5: asynchronous reset while word 2 of 4 is presented.
        rst4 = 1'b1;
        q4.delete(); pos4 = 0; cnt4 = 0;
        @(posedge clk);
        @(negedge clk);
        rst4 = 1'b0;
        for (int i = 0; i < 4; i++) dbg4.dbg_data[i] = $urandom;
        req4 = 1'b1; rdy4 = 1'b1;
        tick();
        req4 = 1'b0;
        tick();
        tick();
        chk("t5_pre_idx", 32'(oi4), 32'd2);
        rst4 = 1'b1;
        #1;
        q4.delete(); pos4 = 0; cnt4 = 0;
        check4();
        @(posedge clk);
        @(negedge clk);
        check4();
        rst4 = 1'b0;
        for (int i = 0; i < 4; i++) dbg4.dbg_data[i] = $urandom;
        req4 = 1'b1;
        tick();
        req4 = 1'b0;
        chk("t5_restart_idx", 32'(oi4), 32'd0);
        repeat (5) tick();
        chk("t5_count", 32'(cnt4o), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
